// File: rtl/convolution_scheduler.sv
// convolution_scheduler: walks all IR/audio line pairs for one output sample,
// accumulates the line convolver partial sums and emits a saturated 16-bit sample.
module convolution_scheduler #(
  parameter int NUM_LINES    = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int READ_LATENCY = 2,
  parameter int OUT_SHIFT    = 15
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         sample_valid_in,
  input  logic        [ADDR_WIDTH-1:0] head_addr_in,
  output logic        [ADDR_WIDTH-1:0] ir_addr_out,
  output logic        [ADDR_WIDTH-1:0] audio_addr_out,
  input  logic signed [47:0]           convolved_line_in,
  output logic signed [15:0]           sample_out,
  output logic                         sample_valid_out,
  output logic                         busy_out,
  output logic                         overrun_out
);
  localparam int AW = 48 + ADDR_WIDTH;
  localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
  localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - AW'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(NUM_LINES - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    head_q, head_d, k_q, k_d;
  logic [READ_LATENCY-1:0]  valid_q, valid_d;
  logic [READ_LATENCY:0]    valid_sh;
  logic signed [AW-1:0]     acc_q, acc_d, acc_sh;
  logic signed [15:0]       sample_q, sample_d;
  logic                     overrun_q, overrun_d, finish;
  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    k_d       = k_q;
    overrun_d = sample_valid_in && state_q != IDLE;
    // each ISSUE cycle tags one read; the tag emerges with its product
    valid_sh  = {valid_q, state_q == ISSUE};
    valid_d   = valid_sh[READ_LATENCY-1:0];
    acc_d     = valid_q[READ_LATENCY-1]
              ? acc_q + {{ADDR_WIDTH{convolved_line_in[47]}}, convolved_line_in}
              : acc_q;
    finish    = state_q == DRAIN && valid_d == '0;
    if (state_q == IDLE && sample_valid_in) begin
      head_d  = head_addr_in;
      k_d     = '0;
      acc_d   = '0;
      state_d = ISSUE;
    end else if (state_q == ISSUE) begin
      k_d     = k_q + 1'b1;
      state_d = k_q == LAST_K ? DRAIN : ISSUE;
    end else if (finish) begin
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    acc_sh   = acc_d >>> OUT_SHIFT;
    sample_d = !finish ? sample_q
             : acc_sh > SAT_MAX ? 16'sh7fff
             : acc_sh < SAT_MIN ? 16'sh8000
             : acc_sh[15:0];
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state_q   <= IDLE;
      head_q    <= '0;
      k_q       <= '0;
      valid_q   <= '0;
      acc_q     <= '0;
      sample_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      k_q       <= k_d;
      valid_q   <= valid_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      overrun_q <= overrun_d;
    end
  assign ir_addr_out      = state_q == ISSUE ? k_q : '0;
  assign audio_addr_out   = state_q == ISSUE ? head_q - k_q : '0;
  assign sample_out       = sample_q;
  assign sample_valid_out = state_q == DONE;
  assign busy_out         = state_q != IDLE;
  assign overrun_out      = overrun_q;
endmodule

// File: tb/tb_convolution_scheduler.sv
// tb_convolution_scheduler: BRAM/convolver model plus scoreboard of expected samples
// and overrun pulses, each tagged with the cycle it must appear in.
module tb_convolution_scheduler;
  logic               clk_in = 1'b0, rst_n_in = 1'b0, sample_valid_in = 1'b0;
  logic        [3:0]  head_addr_in = '0;
  logic        [3:0]  ir_addr_out, audio_addr_out;
  logic signed [47:0] convolved_line_in;
  logic signed [15:0] sample_out;
  logic               sample_valid_out, busy_out, overrun_out;
  logic signed [47:0] tbl [16][16];
  logic        [3:0]  ir1 = '0, ir2 = '0, au1 = '0, au2 = '0;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {int val; int cyc;} exp_t;
  exp_t exp_q[$];
  int   ovr_q[$];

  convolution_scheduler dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .sample_valid_in(sample_valid_in),
    .head_addr_in(head_addr_in), .ir_addr_out(ir_addr_out), .audio_addr_out(audio_addr_out),
    .convolved_line_in(convolved_line_in), .sample_out(sample_out),
    .sample_valid_out(sample_valid_out), .busy_out(busy_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  // two-cycle BRAM read followed by the combinational convolver
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    ir1 <= ir_addr_out;
    ir2 <= ir1;
    au1 <= audio_addr_out;
    au2 <= au1;
  end
  assign convolved_line_in = tbl[ir2][au2];

  function automatic int model(int head);
    longint s = 0;
    for (int k = 0; k < 16; k++) s += longint'(tbl[k][(head - k + 16) % 16]);
    s = s >>> 15;
    return s > 32767 ? 32767 : s < -32768 ? -32768 : int'(s);
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic fill_const(longint v);
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) tbl[i][j] = 48'(v);
  endtask

  task automatic fill_alt();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) tbl[i][j] = (i % 2 == 0) ? 48'(5 * 32768) : -48'(3 * 32768);
  endtask

  task automatic fill_rand();
    longint r;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        r = {$urandom, $urandom};
        tbl[i][j] = 48'(r >>> (16 + $urandom_range(0, 30)));
      end
  endtask

  task automatic start(int head, int exp_val);
    sample_valid_in = 1'b1;
    head_addr_in    = 4'(head);
    exp_q.push_back('{exp_val, cyc + 19});
    tick();
    sample_valid_in = 1'b0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_sample"}, sample_out, 0);
    chk({tag, "_valid"}, sample_valid_out, 0);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_overrun"}, overrun_out, 0);
    chk({tag, "_ir_addr"}, ir_addr_out, 0);
    chk({tag, "_audio_addr"}, audio_addr_out, 0);
  endtask

  // monitor: every output pulse must match the head of its queue in value and cycle
  always @(negedge clk_in) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL sample_missing: not observed, expected %0d at cycle %0d", e.val, e.cyc);
    end
    while (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
      checks++; errors++;
      $display("FAIL overrun_missing: not observed, expected at cycle %0d", ovr_q.pop_front());
    end
    if (sample_valid_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sample_unexpected: got %0d at cycle %0d, expected none", sample_out, cyc);
      end else begin
        e = exp_q.pop_front();
        if (int'(sample_out) != e.val || e.cyc != cyc) begin
          errors++;
          $display("FAIL sample: got %0d at cycle %0d expected %0d at cycle %0d",
                   sample_out, cyc, e.val, e.cyc);
        end
      end
    end
    if (overrun_out) begin
      checks++;
      if (ovr_q.size() == 0 || ovr_q[0] != cyc) begin
        errors++;
        $display("FAIL overrun: pulse at cycle %0d, expected at %0d", cyc,
                 ovr_q.size() > 0 ? ovr_q[0] : -1);
      end else void'(ovr_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int h, c0;
    fill_rand();
    // reset held, with a start request that must be ignored
    idle(2);
    sample_valid_in = 1'b1;
    tick();
    sample_valid_in = 1'b0;
    @(negedge clk_in);
    chk_zero("reset");
    // release with a start on the same edge; check the address walk with head 3
    tick();
    rst_n_in        = 1'b1;
    sample_valid_in = 1'b1;
    head_addr_in    = 4'd3;
    exp_q.push_back('{model(3), cyc + 19});
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk_in);
      chk("ir_addr", ir_addr_out, (i >= 1 && i <= 16) ? i - 1 : 0);
      chk("audio_addr", audio_addr_out, (i >= 1 && i <= 16) ? (3 - (i - 1) + 16) % 16 : 0);
      chk("busy", busy_out, (i >= 1 && i <= 19) ? 1 : 0);
      tick();
      sample_valid_in = 1'b0;
    end
    // accumulation and saturation
    fill_const(32768);
    start(5, 16);
    idle(19);
    fill_const(longint'(1) << 40);
    start(2, 32767);
    idle(19);
    fill_const(-(longint'(1) << 40));
    start(9, -32768);
    idle(19);
    fill_alt();
    start(0, 16);
    idle(19);
    // overrun at c5 and c19, restart at c21
    fill_rand();
    start(7, model(7));
    for (int i = 1; i <= 20; i++) begin
      sample_valid_in = (i == 5 || i == 19);
      head_addr_in    = 4'(i);
      if (sample_valid_in) ovr_q.push_back(cyc + 1);
      tick();
      sample_valid_in = 1'b0;
    end
    start(12, model(12));
    idle(19);
    // reset in c8 of a pass
    fill_rand();
    start(11, model(11));
    idle(7);
    rst_n_in = 1'b0;
    void'(exp_q.pop_back());
    @(negedge clk_in);
    chk_zero("midreset");
    idle(2);
    rst_n_in = 1'b1;
    idle(1);
    start(4, model(4));
    idle(19);
    // randomized passes with stray start requests
    for (int p = 0; p < 30; p++) begin
      fill_rand();
      h = $urandom_range(0, 15);
      c0 = cyc;
      start(h, model(h));
      for (int i = 1; i <= 19; i++) begin
        sample_valid_in = ($urandom_range(0, 9) == 0);
        head_addr_in    = 4'($urandom_range(0, 15));
        if (sample_valid_in) ovr_q.push_back(cyc + 1);
        tick();
        sample_valid_in = 1'b0;
      end
      if (cyc != c0 + 20) $display("bench pacing drifted at pass %0d", p);
      idle($urandom_range(0, 3));
    end
    idle(5);
    chk("sample_queue_empty", exp_q.size(), 0);
    chk("overrun_queue_empty", ovr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
